wubsuit_clk_div: RTL and testbench
==================================

WUBSUIT_CLK_DIV -- requirements
Module: wubsuit_clk_div

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning the number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter DIV_W, default 5, meaning the divisor field width in bits.
REQ-003 The block SHALL have parameter DIV_RESET, default 3, meaning the divisor every channel loads at reset.
REQ-004 The block SHALL have port FAB_CLK  input  1  meaning the single fabric clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RESET  input  1  meaning the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port DIV_WE  input  1  meaning divisor-write strobe, valid for one cycle.
REQ-007 The block SHALL have port DIV_SEL  input  3  meaning the channel index for a write.
REQ-008 The block SHALL have port DIV_VAL  input  DIV_W  meaning the divisor code, where the ratio is DIV_VAL+1.
REQ-009 The block SHALL have port SYNC  input  1  meaning a one-cycle pulse that realigns all channels.
REQ-010 The block SHALL have port CE_OUT  output  NUM_CH  meaning per-channel registered clock-enable pulses.
REQ-011 The block SHALL have port LOCK  output  1  meaning that no divisor update is pending on any channel.

Function
REQ-012 Each channel SHALL hold a counter CNT[i] (DIV_W bits), an active divisor DIV[i], a pending divisor PEND[i], and a one-bit state IDLE/PENDING.
REQ-013 CNT[i] SHALL increment each cycle, and wrap to 0 on the cycle after CNT[i]==DIV[i] (terminal count, TC).
REQ-014 CE_OUT[i] SHALL be a flop output, high for exactly the one cycle in which CNT[i]==DIV[i], giving a period of DIV[i]+1 cycles.
REQ-015 When DIV[i]==0, CE_OUT[i] SHALL be high every cycle (divide-by-1, bypass equivalent).
REQ-016 A write with DIV_WE=1 and DIV_SEL<NUM_CH SHALL load PEND[DIV_SEL]=DIV_VAL and move that channel to PENDING on the next cycle.
REQ-017 A write with DIV_SEL>=NUM_CH SHALL be ignored with no state change.
REQ-018 A write to a channel already in PENDING SHALL overwrite PEND, and the last value written wins.
REQ-019 A PENDING channel SHALL copy PEND into DIV at its first TC occurring after the write cycle, then return to IDLE; a TC in the same cycle as the write SHALL reload the old divisor.
REQ-020 A divisor change SHALL never shorten or truncate an in-progress period, so no runt CE pulse occurs.
REQ-021 LOCK SHALL be registered, equal to the AND of all channel IDLE states, and go low the cycle after any accepted write.

Reset
REQ-022 While RESET=1, the block SHALL force CNT=0, DIV=PEND=DIV_RESET, state=IDLE, CE_OUT=0 and LOCK=0.
REQ-023 The first cycle with RESET=0 SHALL be cycle 1, and LOCK SHALL be 1 from cycle 1.
REQ-024 CE_OUT[i] SHALL first assert in cycle DIV_RESET+1, repeating every DIV_RESET+1 cycles.
REQ-025 RESET asserted mid-period or while PENDING SHALL discard pending writes, and RESET SHALL override SYNC and DIV_WE in the same cycle.

Configuration
REQ-026 With macro WUBSUIT_CLKDIV_SYNC_EN defined, a SYNC pulse SHALL set every CNT to 0 and apply every PENDING value to DIV immediately, with all channels returning to IDLE and their next CE pulses phase-aligned.
REQ-027 With WUBSUIT_CLKDIV_SYNC_EN defined, SYNC coincident with DIV_WE SHALL apply the sync first; the write then becomes pending.
REQ-028 Without WUBSUIT_CLKDIV_SYNC_EN, the SYNC port SHALL remain present but be ignored, with no logic generated for it.

Verification
REQ-029 Bench SHALL cover: reset release with defaults (NUM_CH=3, DIV_RESET=3) -> all CE_OUT high in cycles 4, 8, 12, and LOCK=1 from cycle 1.
REQ-030 Bench SHALL cover: a write of ch0=0 at cycle 5 -> LOCK=0 in cycle 6, CE_OUT[0] high in cycle 8 (old period kept), then high every cycle, and LOCK=1 again in cycle 9.
REQ-031 Bench SHALL cover: a write of ch1=7 followed by ch1=1 before TC -> only divisor 1 applied, giving a period of 2 after the next TC.
REQ-032 Bench SHALL cover: DIV_SEL=5 with NUM_CH=3 -> no change, and LOCK stays 1.
REQ-033 Bench SHALL cover: with SYNC_EN, ch0=2 and ch2=4 free-running, SYNC at cycle 20 -> both CE_OUT first high together in cycle 23 for ch0 and cycle 25 for ch2, with both counters at 0 in cycle 21.
REQ-034 Bench SHALL cover: RESET in cycle 10 while ch1 is PENDING -> cycle 11 has CE_OUT=0, LOCK=0 and DIV=3 for all channels, and the reset sequence restarts.

Source files
------------

// File: rtl/wubsuit_clk_div.sv
// wubsuit_clk_div: multi-channel clock-enable divider; divisor changes apply only at a terminal count.
// Define WUBSUIT_CLKDIV_SYNC_EN to make SYNC realign all counters and apply pending divisors at once.
module wubsuit_clk_div #(
  parameter int NUM_CH    = 3,
  parameter int DIV_W     = 5,
  parameter int DIV_RESET = 3
) (
  input  logic              FAB_CLK,
  input  logic              RESET,
  input  logic              DIV_WE,
  input  logic [2:0]        DIV_SEL,
  input  logic [DIV_W-1:0]  DIV_VAL,
  input  logic              SYNC,
  output logic [NUM_CH-1:0] CE_OUT,
  output logic              LOCK
);
  typedef enum logic {IDLE, PENDING} st_t;
  st_t              st_q   [NUM_CH];
  st_t              st_d   [NUM_CH];
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_d  [NUM_CH];
  logic [DIV_W-1:0] div_q  [NUM_CH];
  logic [DIV_W-1:0] div_d  [NUM_CH];
  logic [DIV_W-1:0] pend_q [NUM_CH];
  logic [DIV_W-1:0] pend_d [NUM_CH];
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] ce_q;
  logic              lock_q;
  logic              lock_d;
`ifndef WUBSUIT_CLKDIV_SYNC_EN
  logic sync_unused;
  assign sync_unused = SYNC;
`endif
  always_comb begin
    lock_d = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      tc[i]     = cnt_q[i] == div_q[i];
      cnt_d[i]  = tc[i] ? '0 : cnt_q[i] + 1'b1;
      // the pending divisor only lands at a period boundary, so no period is ever cut short
      div_d[i]  = (tc[i] && st_q[i] == PENDING) ? pend_q[i] : div_q[i];
      st_d[i]   = (tc[i] && st_q[i] == PENDING) ? IDLE : st_q[i];
`ifdef WUBSUIT_CLKDIV_SYNC_EN
      cnt_d[i]  = SYNC ? '0 : cnt_d[i];
      div_d[i]  = (SYNC && st_q[i] == PENDING) ? pend_q[i] : div_d[i];
      st_d[i]   = SYNC ? IDLE : st_d[i];
`endif
      // a write lands after any sync/TC reload, so it always stays pending
      pend_d[i] = (DIV_WE && DIV_SEL == 3'(i)) ? DIV_VAL : pend_q[i];
      st_d[i]   = (DIV_WE && DIV_SEL == 3'(i)) ? PENDING : st_d[i];
      lock_d    = lock_d & (st_q[i] == IDLE);
    end
  end
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_W'(DIV_RESET);
        pend_q[i] <= DIV_W'(DIV_RESET);
        st_q[i]   <= IDLE;
      end
      ce_q   <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      st_q   <= st_d;
      ce_q   <= tc;
      lock_q <= lock_d;
    end
  end
  assign CE_OUT = ce_q;
  assign LOCK   = lock_q;
endmodule

// File: tb/tb_wubsuit_clk_div.sv
// tb_wubsuit_clk_div: directed scenarios with hand-derived CE_OUT/LOCK waveforms checked by a per-cycle scoreboard.
module tb_wubsuit_clk_div;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic [2:0] sel = '0;
  logic [4:0] val = '0;
  logic       sy  = 1'b0;
  logic [2:0] ce;
  logic       lock;
  typedef struct {
    string      name;
    int         t;
    logic [2:0] ce;
    logic       lock;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int   t = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  logic b0, b1, b2;
  wubsuit_clk_div dut (
    .FAB_CLK(clk), .RESET(rst), .DIV_WE(we), .DIV_SEL(sel), .DIV_VAL(val),
    .SYNC(sy), .CE_OUT(ce), .LOCK(lock)
  );
  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].t < t) begin
      m = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s tick %0d: expectation skipped (now tick %0d)", m.name, m.t, t);
    end
    if (q.size() > 0 && q[0].t == t) begin
      m = q.pop_front();
      checks++;
      if (ce !== m.ce || lock !== m.lock) begin
        errors++;
        $display("FAIL %s cycle %0d: got CE_OUT=%b LOCK=%b, want CE_OUT=%b LOCK=%b",
                 m.name, m.t - base, ce, lock, m.ce, m.lock);
      end
    end
  end
  task automatic push_abs(input string n, input int at, input logic [2:0] e_ce, input logic e_lk);
    exp_t e;
    e.name = n;
    e.t    = at;
    e.ce   = e_ce;
    e.lock = e_lk;
    q.push_back(e);
  endtask
  task automatic push(input string n, input int c, input logic [2:0] e_ce, input logic e_lk);
    push_abs(n, base + c, e_ce, e_lk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;
    sy  = 1'b0;
    @(negedge clk);
    push_abs("reset_state", t + 1, 3'b000, 1'b0);
    @(negedge clk);
    base = t;
    rst  = 1'b0;
  endtask
  task automatic drive_at(input int c, input logic w, input logic [2:0] s, input logic [4:0] v, input logic y);
    while (t < base + c - 1) @(negedge clk);
    we  = w;
    sel = s;
    val = v;
    sy  = y;
    @(negedge clk);
    we = 1'b0;
    sy = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still queued, want 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    do_reset();
    for (int c = 1; c <= 12; c++) push("release_defaults", c, {3{c % 4 == 0}}, 1'b1);
    drain();
    do_reset();
    for (int c = 1; c <= 12; c++)
      push("ch0_to_div1", c, {c % 4 == 0, c % 4 == 0, c % 4 == 0 || c >= 9}, !(c >= 6 && c <= 8));
    drive_at(5, 1'b1, 3'd0, 5'd0, 1'b0);
    drain();
    do_reset();
    for (int c = 1; c <= 16; c++)
      push("ch1_last_write_wins", c,
           {c % 4 == 0, c % 4 == 0 || (c >= 10 && c % 2 == 0), c % 4 == 0}, !(c >= 6 && c <= 8));
    drive_at(5, 1'b1, 3'd1, 5'd7, 1'b0);
    drive_at(6, 1'b1, 3'd1, 5'd1, 1'b0);
    drain();
    do_reset();
    for (int c = 1; c <= 12; c++) push("bad_sel_ignored", c, {3{c % 4 == 0}}, 1'b1);
    drive_at(5, 1'b1, 3'd5, 5'd0, 1'b0);
    drain();
    do_reset();
    for (int c = 1; c <= 30; c++) begin
`ifdef WUBSUIT_CLKDIV_SYNC_EN
      b0 = c inside {4, 7, 10, 13, 16, 19, 23, 26, 29};
      b2 = c inside {4, 9, 14, 19, 25, 30};
`else
      b0 = c inside {4, 7, 10, 13, 16, 19, 22, 25, 28};
      b2 = c inside {4, 9, 14, 19, 24, 29};
`endif
      b1 = c inside {4, 8, 12, 16, 20, 22, 25, 28};
      push("sync_realign", c, {b2, b1, b0}, !((c >= 2 && c <= 4) || (c >= 20 && c <= 22)));
    end
    drive_at(1, 1'b1, 3'd0, 5'd2, 1'b0);
    drive_at(2, 1'b1, 3'd2, 5'd4, 1'b0);
    drive_at(19, 1'b1, 3'd1, 5'd1, 1'b0);
    drive_at(20, 1'b1, 3'd1, 5'd2, 1'b1);
    drain();
    do_reset();
    for (int c = 1; c <= 9; c++) push("reset_while_pending", c, {3{c % 4 == 0}}, 1'b1);
    push("reset_while_pending", 10, 3'b000, 1'b0);
    push("reset_while_pending", 11, 3'b000, 1'b0);
    for (int c = 12; c <= 24; c++) push("reset_while_pending", c, {3{(c - 11) % 4 == 0}}, 1'b1);
    drive_at(9, 1'b1, 3'd1, 5'd0, 1'b0);
    rst = 1'b1;
    we  = 1'b1;
    sel = 3'd0;
    val = 5'd0;
    sy  = 1'b1;
    @(negedge clk);
    we = 1'b0;
    sy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
